// File: rtl/rv32i_types.sv
// Shared scoreboard-pipeline types: functional-unit count, datapath widths and
// the common-data-bus packet seen by the scoreboard and register file.
package rv32i_types;

  localparam int NUM_FU    = 4;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int FU_IDX_W  = $clog2(NUM_FU);

  typedef struct packed {
    logic                 valid;
    logic [FU_IDX_W-1:0]  fu;
    logic                 has_rd;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_rr_arbiter.sv
// Round-robin arbiter: the search starts at rr_ptr and wraps; rr_ptr advances
// past the winner only when the grant is actually taken.
module cdb_rr_arbiter #(
  parameter int NUM_FU = 4,
  parameter int IDX_W  = $clog2(NUM_FU)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_FU-1:0] req,
  input  logic              grant_accept,
  output logic [NUM_FU-1:0] grant,
  output logic [IDX_W-1:0]  winner
);

  logic [IDX_W-1:0] rr_ptr;

  always_comb begin
    automatic int idx;
    automatic logic found;
    idx    = 0;
    found  = 1'b0;
    grant  = '0;
    winner = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx[IDX_W-1:0];
      end
    end
  end

  // Explicit wrap keeps the modulo correct for non-power-of-two NUM_FU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_accept) begin
      if (winner == IDX_W'(NUM_FU - 1)) rr_ptr <= '0;
      else                              rr_ptr <= winner + 1'b1;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Write-result stage: one holding buffer per functional unit, round-robin
// selection of a WAR-cleared result onto the CDB and the register-file write port.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_FU   = rv32i_types::NUM_FU,
  parameter int XLEN     = rv32i_types::XLEN,
  parameter int FU_IDX_W = $clog2(NUM_FU)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [NUM_FU-1:0]               fu_valid,
  input  logic [NUM_FU-1:0]               fu_has_rd,
  input  logic [NUM_FU-1:0][REG_IDX_W-1:0] fu_rd,
  input  logic [NUM_FU-1:0][XLEN-1:0]      fu_result,
  output logic [NUM_FU-1:0]               fu_ready,
  input  logic [NUM_FU-1:0]               wr_ok,
  output logic                            cdb_valid,
  output logic [FU_IDX_W-1:0]             cdb_fu,
  output logic [REG_IDX_W-1:0]            cdb_rd,
  output logic [XLEN-1:0]                 cdb_data,
  output logic                            regf_we,
  output logic [REG_IDX_W-1:0]            regf_rd_s,
  output logic [XLEN-1:0]                 regf_rd_v
);

  logic [NUM_FU-1:0]                buf_valid;
  logic [NUM_FU-1:0]                buf_has_rd;
  logic [NUM_FU-1:0][REG_IDX_W-1:0] buf_rd;
  logic [NUM_FU-1:0][XLEN-1:0]      buf_data;

  logic [NUM_FU-1:0]   req;
  logic [NUM_FU-1:0]   grant;
  logic [FU_IDX_W-1:0] winner;
  logic                win_has_rd;
  logic [REG_IDX_W-1:0] win_rd;
  logic [XLEN-1:0]     win_data;

  // Gating requests with flush forces grant, and hence every CDB output, to zero.
  assign req      = buf_valid & wr_ok & {NUM_FU{!flush}};
  assign fu_ready = {NUM_FU{!flush}} & (~buf_valid | grant);

  cdb_rr_arbiter #(
    .NUM_FU (NUM_FU),
    .IDX_W  (FU_IDX_W)
  ) u_rr (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .grant_accept (|grant && !flush),
    .grant        (grant),
    .winner       (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (flush)                          buf_valid[i] <= 1'b0;
        else if (fu_valid[i] && fu_ready[i]) buf_valid[i] <= 1'b1;
        else if (grant[i])                  buf_valid[i] <= 1'b0;
      end
    end
  end

  // Payload fields are never observed unless buf_valid is set, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_valid[i] && fu_ready[i]) begin
        buf_has_rd[i] <= fu_has_rd[i];
        buf_rd[i]     <= fu_rd[i];
        buf_data[i]   <= fu_result[i];
      end
    end
  end

  always_comb begin
    win_has_rd = 1'b0;
    win_rd     = '0;
    win_data   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        win_has_rd = buf_has_rd[i];
        win_rd     = buf_rd[i];
        win_data   = buf_data[i];
      end
    end
  end

  assign cdb_valid = |grant;
  assign cdb_fu    = winner;
  assign cdb_rd    = win_rd;
  assign cdb_data  = win_data;
  assign regf_we   = cdb_valid && win_has_rd && (win_rd != '0);
  assign regf_rd_s = cdb_rd;
  assign regf_rd_v = cdb_data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: each task drives one scenario and checks the
// CDB / register-file outputs against hand-computed values.
module tb_cdb_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [3:0]       fu_valid;
  logic [3:0]       fu_has_rd;
  logic [3:0][4:0]  fu_rd;
  logic [3:0][31:0] fu_result;
  logic [3:0]       fu_ready;
  logic [3:0]       wr_ok;
  logic             cdb_valid;
  logic [1:0]       cdb_fu;
  logic [4:0]       cdb_rd;
  logic [31:0]      cdb_data;
  logic             regf_we;
  logic [4:0]       regf_rd_s;
  logic [31:0]      regf_rd_v;

  int n_cmp = 0;
  int n_err = 0;

  cdb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_has_rd (fu_has_rd),
    .fu_rd     (fu_rd),
    .fu_result (fu_result),
    .fu_ready  (fu_ready),
    .wr_ok     (wr_ok),
    .cdb_valid (cdb_valid),
    .cdb_fu    (cdb_fu),
    .cdb_rd    (cdb_rd),
    .cdb_data  (cdb_data),
    .regf_we   (regf_we),
    .regf_rd_s (regf_rd_s),
    .regf_rd_v (regf_rd_v)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    fu_valid  = '0;
    fu_has_rd = '0;
    fu_rd     = '0;
    fu_result = '0;
    wr_ok     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    n_cmp++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL reset_cdb_valid got %0h want 0", cdb_valid); end
    n_cmp++; if (regf_we !== 1'b0) begin n_err++; $display("FAIL reset_regf_we got %0h want 0", regf_we); end
    n_cmp++; if (cdb_data !== 32'h0) begin n_err++; $display("FAIL reset_cdb_data got %0h want 0", cdb_data); end
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (fu_ready !== 4'b1111) begin n_err++; $display("FAIL reset_fu_ready got %b want 1111", fu_ready); end
  endtask

  task automatic test_single();
    do_reset();
    wr_ok        = 4'b1111;
    fu_valid[1]  = 1'b1;
    fu_has_rd[1] = 1'b1;
    fu_rd[1]     = 5'd5;
    fu_result[1] = 32'hDEADBEEF;
    #1;
    n_cmp++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL single_pre_valid got %0h want 0", cdb_valid); end
    tick();
    fu_valid = '0;
    #1;
    n_cmp++; if (cdb_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %0h want 1", cdb_valid); end
    n_cmp++; if (cdb_fu !== 2'd1) begin n_err++; $display("FAIL single_fu got %0d want 1", cdb_fu); end
    n_cmp++; if (regf_we !== 1'b1) begin n_err++; $display("FAIL single_we got %0h want 1", regf_we); end
    n_cmp++; if (regf_rd_s !== 5'd5) begin n_err++; $display("FAIL single_rd got %0d want 5", regf_rd_s); end
    n_cmp++; if (regf_rd_v !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data got %h want deadbeef", regf_rd_v); end
    tick();
    n_cmp++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL single_after_valid got %0h want 0", cdb_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    wr_ok     = 4'b1111;
    fu_has_rd = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      fu_rd[i]     = 5'(i + 10);
      fu_result[i] = 32'h1000 + 32'(i);
    end
    fu_valid = 4'b1111;
    tick();
    fu_valid = '0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (cdb_fu !== 2'(i)) begin n_err++; $display("FAIL rr_once_fu[%0d] got %0d want %0d", i, cdb_fu, i); end
      n_cmp++; if (cdb_data !== 32'h1000 + 32'(i)) begin n_err++; $display("FAIL rr_once_data[%0d] got %h want %h", i, cdb_data, 32'h1000 + i); end
      tick();
    end
    n_cmp++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL rr_drained got %0h want 0", cdb_valid); end
    // Every FU reloads each cycle: FU0 must still get only one grant in four.
    fu_valid = 4'b1111;
    tick();
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (cdb_fu !== 2'(k % 4) || cdb_valid !== 1'b1) begin n_err++; $display("FAIL rr_reload_fu[%0d] got %0d want %0d", k, cdb_fu, k % 4); end
      tick();
    end
    fu_valid = '0;
  endtask

  task automatic test_war_stall();
    do_reset();
    wr_ok        = 4'b0001;
    fu_has_rd    = 4'b0101;
    fu_rd[0]     = 5'd1;
    fu_rd[2]     = 5'd2;
    fu_result[2] = 32'h222;
    fu_result[0] = 32'd100;
    fu_valid     = 4'b0101;
    tick();
    fu_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (cdb_fu !== 2'd0 || cdb_data !== 32'(100 + k)) begin n_err++; $display("FAIL war_stream[%0d] got fu=%0d data=%0d want fu=0 data=%0d", k, cdb_fu, cdb_data, 100 + k); end
      n_cmp++; if (fu_ready[2] !== 1'b0) begin n_err++; $display("FAIL war_ready2[%0d] got %0h want 0", k, fu_ready[2]); end
      fu_result[0] = 32'(101 + k);
      if (k == 4) fu_valid = '0;
      tick();
    end
    n_cmp++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL war_held got %0h want 0", cdb_valid); end
    wr_ok = 4'b0101;
    #1;
    n_cmp++; if (cdb_valid !== 1'b1 || cdb_fu !== 2'd2 || cdb_data !== 32'h222) begin n_err++; $display("FAIL war_release got v=%0h fu=%0d data=%h want v=1 fu=2 data=222", cdb_valid, cdb_fu, cdb_data); end
    tick();
    n_cmp++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL war_after got %0h want 0", cdb_valid); end
  endtask

  task automatic test_no_rd();
    do_reset();
    wr_ok        = 4'b1111;
    fu_has_rd    = 4'b0001;
    fu_rd[3]     = 5'd7;
    fu_rd[0]     = 5'd0;
    fu_result[3] = 32'h33;
    fu_result[0] = 32'h44;
    fu_valid     = 4'b1001;
    tick();
    fu_valid = '0;
    n_cmp++; if (cdb_valid !== 1'b1 || cdb_fu !== 2'd0) begin n_err++; $display("FAIL x0_valid got v=%0h fu=%0d want v=1 fu=0", cdb_valid, cdb_fu); end
    n_cmp++; if (regf_we !== 1'b0) begin n_err++; $display("FAIL x0_we got %0h want 0", regf_we); end
    tick();
    n_cmp++; if (cdb_valid !== 1'b1 || cdb_fu !== 2'd3 || cdb_rd !== 5'd7) begin n_err++; $display("FAIL nord_valid got v=%0h fu=%0d rd=%0d want v=1 fu=3 rd=7", cdb_valid, cdb_fu, cdb_rd); end
    n_cmp++; if (regf_we !== 1'b0) begin n_err++; $display("FAIL nord_we got %0h want 0", regf_we); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr_ok        = 4'b0010;
    fu_has_rd[1] = 1'b1;
    fu_rd[1]     = 5'd9;
    fu_valid[1]  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fu_result[1] = 32'hA0 + 32'(k);
      #1;
      n_cmp++; if (fu_ready[1] !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got %0h want 1", k, fu_ready[1]); end
      if (k == 2) begin
        tick();
        fu_valid = '0;
      end else begin
        tick();
      end
      n_cmp++; if (cdb_valid !== 1'b1 || regf_we !== 1'b1 || cdb_data !== 32'hA0 + 32'(k)) begin n_err++; $display("FAIL b2b_data[%0d] got v=%0h we=%0h data=%h want 1 1 %h", k, cdb_valid, regf_we, cdb_data, 32'hA0 + k); end
    end
    tick();
    n_cmp++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end got %0h want 0", cdb_valid); end
  endtask

  task automatic test_flush_and_reset();
    do_reset();
    wr_ok     = 4'b1111;
    fu_has_rd = 4'b0101;
    fu_rd[0]  = 5'd3;
    fu_rd[2]  = 5'd4;
    fu_valid  = 4'b0101;
    tick();
    fu_valid = '0;
    n_cmp++; if (cdb_valid !== 1'b1) begin n_err++; $display("FAIL flush_pre got %0h want 1", cdb_valid); end
    flush = 1'b1;
    #1;
    n_cmp++; if (cdb_valid !== 1'b0 || regf_we !== 1'b0) begin n_err++; $display("FAIL flush_cycle got v=%0h we=%0h want 0 0", cdb_valid, regf_we); end
    n_cmp++; if (fu_ready !== 4'b0000) begin n_err++; $display("FAIL flush_ready got %b want 0000", fu_ready); end
    tick();
    flush = 1'b0;
    #1;
    n_cmp++; if (cdb_valid !== 1'b0 || fu_ready !== 4'b1111) begin n_err++; $display("FAIL flush_after got v=%0h ready=%b want 0 1111", cdb_valid, fu_ready); end
    wr_ok     = 4'b0000;
    fu_has_rd = 4'b1010;
    fu_rd[1]  = 5'd6;
    fu_rd[3]  = 5'd8;
    fu_result[1] = 32'h5555;
    fu_valid  = 4'b1010;
    tick();
    fu_valid = '0;
    wr_ok    = 4'b1111;
    #1;
    n_cmp++; if (cdb_valid !== 1'b1 || regf_we !== 1'b1) begin n_err++; $display("FAIL areset_pre got v=%0h we=%0h want 1 1", cdb_valid, regf_we); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cdb_valid !== 1'b0 || regf_we !== 1'b0 || cdb_data !== 32'h0) begin n_err++; $display("FAIL areset_now got v=%0h we=%0h data=%h want 0 0 0", cdb_valid, regf_we, cdb_data); end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (cdb_valid !== 1'b0) begin n_err++; $display("FAIL areset_after got %0h want 0", cdb_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_war_stall();
    test_no_rd();
    test_back_to_back();
    test_flush_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
